// File: rtl/led_frame_sequencer.sv
// APA102-style frame sequencer: start frame, one brightness/colour word per LED
// fetched from pixel RAM, then an end frame, driven through a start/busy byte writer.
module led_frame_sequencer #(
    parameter int NUM_LEDS        = 60,
    parameter int ADDR_WIDTH      = 6,
    parameter int END_FRAME_BYTES = 4
) (
    input  logic                  spi_clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic [4:0]            global_brightness,
    output logic [ADDR_WIDTH-1:0] pixel_addr,
    input  logic [23:0]           pixel_data,
    output logic                  spi_start,
    output logic [7:0]            spi_data_out,
    input  logic                  spi_busy,
    output logic                  frame_busy,
    output logic                  frame_done
);

    localparam int CNT_MAX = (END_FRAME_BYTES > 4) ? END_FRAME_BYTES : 4;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      LAST_WORD_BYTE = CNT_W'(3);
    localparam logic [CNT_W-1:0]      LAST_END_BYTE  = CNT_W'(END_FRAME_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_LED       = ADDR_WIDTH'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_FRAME,
        S_FETCH,
        S_PIX_WAIT,
        S_LED_BYTES,
        S_END_FRAME,
        S_DONE
    } state_t;

    // Each byte is a REQ phase (start held until busy is seen) then a WAIT phase.
    typedef enum logic {
        PH_REQ,
        PH_WAIT
    } phase_t;

    state_t                state, next_state;
    phase_t                phase, next_phase;
    logic [CNT_W-1:0]      byte_cnt, next_cnt;
    logic [ADDR_WIDTH-1:0] led_idx, next_idx;
    logic [4:0]            brightness;
    logic [23:0]           pixel_hold;
    logic                  sending;
    logic                  byte_done;
    logic                  accept;

    // State register
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            phase    <= PH_REQ;
            byte_cnt <= '0;
            led_idx  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of process ordering.
            state    <= next_state;
            phase    <= next_phase;
            byte_cnt <= next_cnt;
            led_idx  <= next_idx;
        end
    end

    // Frame parameters captured at accept, pixel word captured once RAM data is valid
    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            brightness <= '0;
            pixel_hold <= '0;
        end else begin
            if (accept) begin
                brightness <= global_brightness;
            end
            if (state == S_PIX_WAIT) begin
                pixel_hold <= pixel_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        next_state = state;
        next_phase = phase;
        next_cnt   = byte_cnt;
        next_idx   = led_idx;
        accept     = 1'b0;
        byte_done  = 1'b0;
        sending    = (state == S_START_FRAME) || (state == S_LED_BYTES) ||
                     (state == S_END_FRAME);

        if (sending) begin
            if (phase == PH_REQ) begin
                if (spi_busy) begin
                    next_phase = PH_WAIT;
                end
            end else if (!spi_busy) begin
                next_phase = PH_REQ;
                byte_done  = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                // A writer still finishing a byte (e.g. after reset) blocks a new frame.
                if (frame_start && !spi_busy) begin
                    accept     = 1'b1;
                    next_state = S_START_FRAME;
                    next_phase = PH_REQ;
                    next_cnt   = '0;
                    next_idx   = '0;
                end
            end
            S_START_FRAME: begin
                if (byte_done) begin
                    if (byte_cnt == LAST_WORD_BYTE) begin
                        next_cnt   = '0;
                        next_state = S_FETCH;
                    end else begin
                        next_cnt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            S_FETCH: begin
                next_state = S_PIX_WAIT;
            end
            S_PIX_WAIT: begin
                next_state = S_LED_BYTES;
                next_phase = PH_REQ;
                next_cnt   = '0;
            end
            S_LED_BYTES: begin
                if (byte_done) begin
                    if (byte_cnt == LAST_WORD_BYTE) begin
                        next_cnt = '0;
                        if (led_idx == LAST_LED) begin
                            next_state = S_END_FRAME;
                        end else begin
                            next_idx   = led_idx + ADDR_WIDTH'(1);
                            next_state = S_FETCH;
                        end
                    end else begin
                        next_cnt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            S_END_FRAME: begin
                if (byte_done) begin
                    if (byte_cnt == LAST_END_BYTE) begin
                        next_cnt   = '0;
                        next_state = S_DONE;
                    end else begin
                        next_cnt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: purely from registered state, so reset clears it immediately
    always_comb begin
        spi_start    = 1'b0;
        spi_data_out = 8'h00;
        pixel_addr   = led_idx;
        frame_busy   = (state != S_IDLE) && (state != S_DONE);
        frame_done   = (state == S_DONE);

        case (state)
            S_START_FRAME: begin
                spi_start    = (phase == PH_REQ);
                spi_data_out = 8'h00;
            end
            S_LED_BYTES: begin
                spi_start = (phase == PH_REQ);
                case (byte_cnt)
                    CNT_W'(0): spi_data_out = {3'b111, brightness};
                    CNT_W'(1): spi_data_out = pixel_hold[7:0];
                    CNT_W'(2): spi_data_out = pixel_hold[15:8];
                    default:   spi_data_out = pixel_hold[23:16];
                endcase
            end
            S_END_FRAME: begin
                spi_start    = (phase == PH_REQ);
                spi_data_out = 8'hFF;
            end
            default: begin
                spi_start    = 1'b0;
                spi_data_out = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a behavioural byte writer and pixel RAM.
module tb_led_frame_sequencer;

    localparam int NUM_LEDS = 3;
    localparam int AW       = 2;
    localparam int EFB      = 1;
    localparam int BUSY_LEN = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic [4:0]    global_brightness;
    logic [AW-1:0] pixel_addr;
    logic [23:0]   pixel_data = '0;
    logic          spi_start;
    logic [7:0]    spi_data_out;
    logic          spi_busy;
    logic          frame_busy;
    logic          frame_done;

    logic [23:0] ram [4];
    logic [7:0]  bytes [$];
    logic        wr_busy   = 1'b0;
    int          wr_cnt    = 0;
    logic        hold_busy = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_gaps = 0;
    int start_rises = 0;

    logic       prev_start = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_rst   = 1'b0;

    logic [7:0] exp_a [17];
    logic [7:0] exp_c [17];

    led_frame_sequencer #(
        .NUM_LEDS(NUM_LEDS),
        .ADDR_WIDTH(AW),
        .END_FRAME_BYTES(EFB)
    ) dut (
        .spi_clk(clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .global_brightness(global_brightness),
        .pixel_addr(pixel_addr),
        .pixel_data(pixel_data),
        .spi_start(spi_start),
        .spi_data_out(spi_data_out),
        .spi_busy(spi_busy),
        .frame_busy(frame_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign spi_busy = wr_busy | hold_busy;

    always @(posedge clk) pixel_data <= ram[pixel_addr];

    // Writer: busy the cycle after start, captures data one cycle later, idle after BUSY_LEN
    always @(posedge clk) begin
        if (wr_cnt == 0) begin
            if (spi_start && !spi_busy) begin
                wr_busy <= 1'b1;
                wr_cnt  <= 1;
            end
        end else if (wr_cnt == 1) begin
            bytes.push_back(spi_data_out);
            wr_cnt <= 2;
        end else if (wr_cnt >= BUSY_LEN) begin
            wr_busy <= 1'b0;
            wr_cnt  <= 0;
        end else begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Handshake monitor
    always @(negedge clk) begin
        if (reset_n && prev_rst) begin
            if (spi_start && !prev_start) begin
                start_rises++;
                check("start_rise_while_busy", {31'd0, spi_busy}, 32'd0);
            end
            if (!spi_start && prev_start)
                check("start_fall_before_busy", {31'd0, prev_busy}, 32'd1);
            if (spi_start && prev_start)
                check("data_stable", {24'd0, spi_data_out}, {24'd0, prev_data});
            if (spi_start && !frame_busy)
                busy_gaps++;
        end
        if (frame_done) done_cnt++;
        prev_start = spi_start;
        prev_busy  = spi_busy;
        prev_data  = spi_data_out;
        prev_rst   = reset_n;
    end

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bytes.size() >= n) seen = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, {31'd0, spi_start}, 32'd0);
        check({tag, "_data"}, {24'd0, spi_data_out}, 32'd0);
        check({tag, "_addr"}, {30'd0, pixel_addr}, 32'd0);
        check({tag, "_fbusy"}, {31'd0, frame_busy}, 32'd0);
        check({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int gap;
        int rises0;

        exp_a = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h22, 8'h11,
                  8'hFF, 8'h66, 8'h55, 8'h44, 8'hFF, 8'h99, 8'h88, 8'h77, 8'hFF};
        exp_c = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE3, 8'h33, 8'h22, 8'h11,
                  8'hE3, 8'h66, 8'h55, 8'h44, 8'hE3, 8'h99, 8'h88, 8'h77, 8'hFF};
        ram[0] = 24'h112233;
        ram[1] = 24'h445566;
        ram[2] = 24'h778899;
        ram[3] = 24'h000000;

        reset_n           = 1'b0;
        frame_start       = 1'b0;
        global_brightness = 5'h1F;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A: single pulse; mid-frame pulse and brightness change must be ignored
        bytes.delete();
        done_cnt  = 0;
        busy_gaps = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("a_accept_busy", {31'd0, frame_busy}, 32'd1);
        wait_bytes(8, 2000, seen);
        check("a_reach_8_bytes", {31'd0, seen}, 32'd1);
        frame_start       = 1'b1;
        global_brightness = 5'h03;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done(3000, seen);
        check("a_done_seen", {31'd0, seen}, 32'd1);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 17; i++)
            check($sformatf("a_byte%0d", i), {24'd0, bytes[i]}, {24'd0, exp_a[i]});
        check("a_len", bytes.size(), 32'd17);
        check("a_done_pulses", done_cnt, 32'd1);
        check("a_busy_gaps", busy_gaps, 32'd0);
        check("a_idle_after", {31'd0, frame_busy}, 32'd0);

        // Frame B: RAM slot 2 rewritten while LED 0 is being sent
        global_brightness = 5'h1F;
        bytes.delete();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_bytes(6, 2000, seen);
        check("b_reach_6_bytes", {31'd0, seen}, 32'd1);
        ram[2] = 24'hABCDEF;
        wait_done(3000, seen);
        check("b_done_seen", {31'd0, seen}, 32'd1);
        repeat (10) @(negedge clk);
        check("b_len", bytes.size(), 32'd17);
        check("b_led0_b", {24'd0, bytes[5]}, 32'h33);
        check("b_led2_hdr", {24'd0, bytes[12]}, 32'hFF);
        check("b_led2_b", {24'd0, bytes[13]}, 32'hEF);
        check("b_led2_g", {24'd0, bytes[14]}, 32'hCD);
        check("b_led2_r", {24'd0, bytes[15]}, 32'hAB);
        check("b_end", {24'd0, bytes[16]}, 32'hFF);
        ram[2] = 24'h778899;

        // Frame C: frame_start held for two back-to-back frames, brightness 0x03
        global_brightness = 5'h03;
        bytes.delete();
        done_cnt = 0;
        frame_start = 1'b1;
        wait_done(3000, seen);
        check("c_done1_seen", {31'd0, seen}, 32'd1);
        gap = 0;
        while (!spi_start && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("c_restart_gap", gap, 32'd2);
        wait_done(3000, seen);
        frame_start = 1'b0;
        check("c_done2_seen", {31'd0, seen}, 32'd1);
        repeat (40) @(negedge clk);
        check("c_len", bytes.size(), 32'd34);
        for (int i = 0; i < 34; i++)
            check($sformatf("c_byte%0d", i), {24'd0, bytes[i]}, {24'd0, exp_c[i % 17]});
        check("c_done_pulses", done_cnt, 32'd2);

        // Frame D: reset during LED 1's G byte while the writer stays busy
        global_brightness = 5'h1F;
        bytes.delete();
        frame_start = 1'b1;
        wait_bytes(10, 2000, seen);
        check("d_reach_10_bytes", {31'd0, seen}, 32'd1);
        gap = 0;
        while (!spi_start && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        check("d_g_req_seen", {31'd0, spi_start}, 32'd1);
        check("d_g_req_data", {24'd0, spi_data_out}, 32'h55);
        #2;
        hold_busy = 1'b1;
        reset_n   = 1'b0;
        #1;
        check_reset_outputs("d_async");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        rises0 = start_rises;
        repeat (10) @(negedge clk);
        check("d_no_start_while_busy", start_rises - rises0, 32'd0);
        check("d_not_accepted", {31'd0, frame_busy}, 32'd0);
        bytes.delete();
        hold_busy = 1'b0;
        wait_done(3000, seen);
        frame_start = 1'b0;
        check("d_done_seen", {31'd0, seen}, 32'd1);
        repeat (40) @(negedge clk);
        check("d_len", bytes.size(), 32'd17);
        for (int i = 0; i < 5; i++)
            check($sformatf("d_byte%0d", i), {24'd0, bytes[i]}, {24'd0, exp_a[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
